spu_result_pipe: RTL and testbench
==================================

# spu_result_pipe

Parametrised per-lane result-staging pipeline for the SPU dual-issue core, generalising the fixed two-lane, seven-stage packed result chain between register fetch and writeback. It accepts one issued result entry per lane per cycle and shifts it through DEPTH stages. It exposes every stage as a packed tap for hazard detection, and drives register-file writeback from the last stage. It adds latency-aware forwarding lookup, same-address writeback arbitration and issue-slot flush, none of which the fixed chain has.

## Interface
- LANES, 2, number of issue lanes (lane 0 = even, lane 1 = odd; higher index is later in program order)
- DEPTH, 7, pipeline stages; minimum 2
- DATA_W, 128, result width
- ADDR_W, 7, register address width
- LAT_W, 4, latency field width
- UNIT_W, 3, unit-id field width
- NUM_RD, 6, forwarding lookup ports
- PACK_W, DATA_W+ADDR_W+1+LAT_W+UNIT_W (143), packed entry width, order {data, reg_dst, reg_wr, latency, unit_id}
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  kill this cycle's issue slots
- in_valid  in  LANES  issue strobe per lane
- in_entry  in  LANES*PACK_W  packed issue entry per lane
- tap  out  LANES*DEPTH*PACK_W  stage k (1..DEPTH) of lane l; killed or empty stages read all-zero
- wb_en  out  LANES  writeback enable
- wb_addr  out  LANES*ADDR_W  writeback register
- wb_data  out  LANES*DATA_W  writeback data
- fwd_addr  in  NUM_RD*ADDR_W  lookup register address
- fwd_hit  out  NUM_RD  matching entry whose result is ready
- fwd_pending  out  NUM_RD  youngest match not yet ready (stall request)
- fwd_data  out  NUM_RD*DATA_W  forwarded data; zero when no hit

## Operation
- Stage 1 captures in_entry when in_valid=1 and flush=0. Otherwise it captures all-zero.
- Each stage k+1 takes stage k every cycle. There is no stall, and every entry advances unconditionally.
- Stage age is its index k. An entry is ready when k >= eff_lat.
  - eff_lat is latency with 0 treated as 1, clamped to DEPTH.
- Writeback is combinational from stage DEPTH.
  - wb_en[l] = reg_wr, with wb_addr and wb_data taken from that entry.
  - Collision: two or more lanes with wb_en and equal wb_addr in the same cycle. The highest lane keeps wb_en; the others are forced to 0, and their addr and data are zeroed.
- Forwarding, combinational, for each port:
  - Scan stages youngest first (k=1..DEPTH). Within a stage, scan the highest lane first.
  - The first entry with reg_wr=1 and reg_dst==fwd_addr decides the result.
  - If that entry is ready: fwd_hit=1 and fwd_data = its data.
  - If it is not ready: fwd_pending=1 and fwd_hit=0. Older ready matches are never used, because that would be a WAW hazard.
  - No match: all outputs 0.
- Flush only affects the stage-1 capture. Entries already in stages 1..DEPTH are untouched and complete writeback.

## Timing
- Reset: all stage registers zero, therefore tap, wb_*, fwd_* are all 0.
- Reset applied mid-operation discards all in-flight entries immediately, asynchronously.
- Issue at cycle t appears on tap stage 1 at t+1 and on wb_* during cycle t+DEPTH.
- One entry per lane per cycle with no back-pressure. Throughput is LANES per cycle.
- Forward outputs follow register state within the same cycle. Ready status changes exactly when an entry crosses the stage equal to eff_lat.
- Simultaneous flush and in_valid: flush wins.

## Configuration
- SPU_RESULT_PIPE_FWD_EN defined: forwarding lookup logic is built as described.
- Not defined: fwd_hit, fwd_pending and fwd_data are tied to 0 and fwd_addr is ignored. Ports remain so the instantiation is unchanged. Taps and writeback are unaffected.

## Structure
- Shared package spu_pipe_pkg holds:
  - PACK_W and the field offset constants.
  - pack and unpack functions.
  - An eff_lat function.
- One sub-module, spu_fwd_lookup: a single forwarding port instanced NUM_RD times under the macro.

## Test plan
- Reset: hold rst=0 with random inputs, then release → all outputs 0; first issue at t gives wb_en at t+7.
- Latency: lane 0 issues reg 5, data 0xAA…, latency 2, and port 0 queries reg 5.
  - Cycle t+1 → pending=1, hit=0.
  - Cycle t+2 → hit=1, data 0xAA….
  - Cycle t+7 → wb_en[0]=1, wb_addr=5.
- WAW: lane 1 issues reg 9 with latency 6 one cycle after lane 0 issues reg 9 with latency 1 → query reg 9 gives pending=1 (not the older ready entry) until the younger entry reaches stage 6.
- Collision: both lanes issue reg 3 in the same cycle → at writeback wb_en=2'b10, wb_addr[1]=3.
- Flush: in_valid=11 and flush=1 → stage-1 taps zero; entries issued the cycle before still write back.
- Parameters LANES=3, DEPTH=4: three-lane issue with latency 9 → clamped, ready at stage 4, writeback at t+4.

Source files
------------

// File: rtl/spu_pipe_pkg.sv
// Shared definitions for the SPU result-staging pipeline.
// Holds the default geometry, packed-entry field offsets, pack/unpack helpers
// and the effective-latency function used by writeback and forwarding.
// Entry layout (MSB..LSB): {data, reg_dst, reg_wr, latency, unit_id}.
package spu_pipe_pkg;

    localparam int unsigned SPU_LANES  = 2;
    localparam int unsigned SPU_DEPTH  = 7;
    localparam int unsigned SPU_DATA_W = 128;
    localparam int unsigned SPU_ADDR_W = 7;
    localparam int unsigned SPU_LAT_W  = 4;
    localparam int unsigned SPU_UNIT_W = 3;
    localparam int unsigned SPU_NUM_RD = 6;
    localparam int unsigned SPU_PACK_W = SPU_DATA_W + SPU_ADDR_W + 1 + SPU_LAT_W + SPU_UNIT_W;

    // Field offsets, generic in the field widths
    function automatic int unsigned lat_off(input int unsigned unit_w);
        return unit_w;
    endfunction

    function automatic int unsigned wr_off(input int unsigned unit_w, input int unsigned lat_w);
        return unit_w + lat_w;
    endfunction

    function automatic int unsigned dst_off(input int unsigned unit_w, input int unsigned lat_w);
        return unit_w + lat_w + 1;
    endfunction

    function automatic int unsigned data_off(input int unsigned unit_w, input int unsigned lat_w,
                                             input int unsigned addr_w);
        return unit_w + lat_w + 1 + addr_w;
    endfunction

    typedef struct packed {
        logic [SPU_DATA_W-1:0] data;
        logic [SPU_ADDR_W-1:0] reg_dst;
        logic                  reg_wr;
        logic [SPU_LAT_W-1:0]  latency;
        logic [SPU_UNIT_W-1:0] unit_id;
    } spu_entry_t;

    function automatic logic [SPU_PACK_W-1:0] pack_entry(input spu_entry_t e);
        return SPU_PACK_W'(e);
    endfunction

    function automatic spu_entry_t unpack_entry(input logic [SPU_PACK_W-1:0] v);
        return spu_entry_t'(v);
    endfunction

    // Latency 0 behaves as 1; anything beyond the pipe is ready at the last stage
    function automatic int unsigned eff_lat(input int unsigned lat, input int unsigned depth);
        if (lat == 0) begin
            return 32'd1;
        end else if (lat > depth) begin
            return depth;
        end
        return lat;
    endfunction

endpackage

// File: rtl/spu_fwd_lookup.sv
// Single forwarding lookup port.
// Scans every stage tap youngest first (stage 1..DEPTH), highest lane first
// within a stage. The first live entry writing addr decides: ready -> hit with
// its data, not ready -> pending (older ready matches are WAW-stale).
// Ports: tap (all stages, lane-major), addr (lookup register),
//        hit / pending / data (data zero unless hit).
module spu_fwd_lookup
    import spu_pipe_pkg::*;
#(
    parameter  int unsigned LANES  = SPU_LANES,
    parameter  int unsigned DEPTH  = SPU_DEPTH,
    parameter  int unsigned DATA_W = SPU_DATA_W,
    parameter  int unsigned ADDR_W = SPU_ADDR_W,
    parameter  int unsigned LAT_W  = SPU_LAT_W,
    parameter  int unsigned UNIT_W = SPU_UNIT_W,
    localparam int unsigned PACK_W = DATA_W + ADDR_W + 1 + LAT_W + UNIT_W
)(
    input  logic [LANES*DEPTH*PACK_W-1:0] tap,
    input  logic [ADDR_W-1:0]             addr,
    output logic                          hit,
    output logic                          pending,
    output logic [DATA_W-1:0]             data
);

    localparam int unsigned LAT_OFF  = lat_off(UNIT_W);
    localparam int unsigned WR_OFF   = wr_off(UNIT_W, LAT_W);
    localparam int unsigned DST_OFF  = dst_off(UNIT_W, LAT_W);
    localparam int unsigned DATA_OFF = data_off(UNIT_W, LAT_W, ADDR_W);

    logic [PACK_W-1:0] ent;
    logic              found;
    logic              ready;
    logic [DATA_W-1:0] match_data;

    // Walk lowest priority first so the last match written is the winner
    always_comb begin
        ent        = '0;
        found      = 1'b0;
        ready      = 1'b0;
        match_data = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            for (int l = 0; l < int'(LANES); l++) begin
                ent = tap[(l*int'(DEPTH) + k)*int'(PACK_W) +: PACK_W];
                if (ent[WR_OFF] && (ent[DST_OFF +: ADDR_W] == addr)) begin
                    found      = 1'b1;
                    ready      = unsigned'(k + 1) >= eff_lat(32'(ent[LAT_OFF +: LAT_W]), DEPTH);
                    match_data = ent[DATA_OFF +: DATA_W];
                end
            end
        end
    end

    assign hit     = found & ready;
    assign pending = found & ~ready;
    assign data    = (found & ready) ? match_data : '0;

    // unit_id bits are carried in the taps but play no part in forwarding
    logic unused_tap;
    assign unused_tap = ^tap;

endmodule

// File: rtl/spu_result_pipe.sv
// Per-lane result-staging pipeline for the SPU dual-issue core.
// Each lane shifts one issued entry per cycle through DEPTH stages; every
// stage is exposed as a tap, stage DEPTH drives register-file writeback with
// same-address arbitration (highest lane wins), and optional forwarding
// lookup ports are built when SPU_RESULT_PIPE_FWD_EN is defined (otherwise
// the fwd_* outputs are tied to zero and fwd_addr is ignored).
// Ports: clk, rst (async active-low), flush, in_valid/in_entry (issue),
//        tap (lane l stage k at ((l*DEPTH)+k-1)*PACK_W), wb_en/wb_addr/wb_data,
//        fwd_addr/fwd_hit/fwd_pending/fwd_data.
module spu_result_pipe
    import spu_pipe_pkg::*;
#(
    parameter  int unsigned LANES  = SPU_LANES,
    parameter  int unsigned DEPTH  = SPU_DEPTH,
    parameter  int unsigned DATA_W = SPU_DATA_W,
    parameter  int unsigned ADDR_W = SPU_ADDR_W,
    parameter  int unsigned LAT_W  = SPU_LAT_W,
    parameter  int unsigned UNIT_W = SPU_UNIT_W,
    parameter  int unsigned NUM_RD = SPU_NUM_RD,
    localparam int unsigned PACK_W = DATA_W + ADDR_W + 1 + LAT_W + UNIT_W
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [LANES-1:0]              in_valid,
    input  logic [LANES*PACK_W-1:0]       in_entry,
    output logic [LANES*DEPTH*PACK_W-1:0] tap,
    output logic [LANES-1:0]              wb_en,
    output logic [LANES*ADDR_W-1:0]       wb_addr,
    output logic [LANES*DATA_W-1:0]       wb_data,
    input  logic [NUM_RD*ADDR_W-1:0]      fwd_addr,
    output logic [NUM_RD-1:0]             fwd_hit,
    output logic [NUM_RD-1:0]             fwd_pending,
    output logic [NUM_RD*DATA_W-1:0]      fwd_data
);

    localparam int unsigned WR_OFF   = wr_off(UNIT_W, LAT_W);
    localparam int unsigned DST_OFF  = dst_off(UNIT_W, LAT_W);
    localparam int unsigned DATA_OFF = data_off(UNIT_W, LAT_W, ADDR_W);

    logic [LANES-1:0][DEPTH-1:0][PACK_W-1:0] stage_q;
    logic [LANES-1:0]                        wb_kill;

    // Unconditional shift; flushed or idle issue slots enter as bubbles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            for (int l = 0; l < int'(LANES); l++) begin
                stage_q[l][0] <= (in_valid[l] && !flush) ? in_entry[l*int'(PACK_W) +: PACK_W] : '0;
                for (int k = 1; k < int'(DEPTH); k++) begin
                    stage_q[l][k] <= stage_q[l][k-1];
                end
            end
        end
    end

    assign tap = stage_q;

    // A lane loses writeback when any later lane writes the same register
    always_comb begin
        wb_kill = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            for (int m = l + 1; m < int'(LANES); m++) begin
                if (stage_q[l][DEPTH-1][WR_OFF] && stage_q[m][DEPTH-1][WR_OFF] &&
                    (stage_q[l][DEPTH-1][DST_OFF +: ADDR_W] == stage_q[m][DEPTH-1][DST_OFF +: ADDR_W])) begin
                    wb_kill[l] = 1'b1;
                end
            end
        end
    end

    // Writeback straight from the last stage, killed lanes fully zeroed
    always_comb begin
        wb_en   = '0;
        wb_addr = '0;
        wb_data = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            if (!wb_kill[l]) begin
                wb_en[l]                           = stage_q[l][DEPTH-1][WR_OFF];
                wb_addr[l*int'(ADDR_W) +: ADDR_W]  = stage_q[l][DEPTH-1][DST_OFF +: ADDR_W];
                wb_data[l*int'(DATA_W) +: DATA_W]  = stage_q[l][DEPTH-1][DATA_OFF +: DATA_W];
            end
        end
    end

`ifdef SPU_RESULT_PIPE_FWD_EN
    for (genvar r = 0; r < int'(NUM_RD); r++) begin : g_fwd
        spu_fwd_lookup #(
            .LANES  (LANES),
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .LAT_W  (LAT_W),
            .UNIT_W (UNIT_W)
        ) u_fwd (
            .tap     (stage_q),
            .addr    (fwd_addr[r*int'(ADDR_W) +: ADDR_W]),
            .hit     (fwd_hit[r]),
            .pending (fwd_pending[r]),
            .data    (fwd_data[r*int'(DATA_W) +: DATA_W])
        );
    end
`else
    assign fwd_hit     = '0;
    assign fwd_pending = '0;
    assign fwd_data    = '0;

    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr;
`endif

endmodule

// File: tb/tb_spu_result_pipe.sv
module tb_spu_result_pipe;
    import spu_pipe_pkg::*;

    localparam int unsigned L  = 2;
    localparam int unsigned D  = 7;
    localparam int unsigned DW = 128;
    localparam int unsigned AW = 7;
    localparam int unsigned LW = 4;
    localparam int unsigned UW = 3;
    localparam int unsigned NR = 6;
    localparam int unsigned PW = DW + AW + 1 + LW + UW;
    localparam int unsigned L3 = 3;
    localparam int unsigned D3 = 4;
`ifdef SPU_RESULT_PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                flush = 1'b0;
    logic [L-1:0]        in_valid = '0;
    logic [L*PW-1:0]     in_entry = '0;
    logic [L*D*PW-1:0]   tap;
    logic [L-1:0]        wb_en;
    logic [L*AW-1:0]     wb_addr;
    logic [L*DW-1:0]     wb_data;
    logic [NR*AW-1:0]    fwd_addr = '0;
    logic [NR-1:0]       fwd_hit;
    logic [NR-1:0]       fwd_pending;
    logic [NR*DW-1:0]    fwd_data;

    logic [L3-1:0]       in_valid3 = '0;
    logic [L3*PW-1:0]    in_entry3 = '0;
    logic [L3*D3*PW-1:0] tap3;
    logic [L3-1:0]       wb_en3;
    logic [L3*AW-1:0]    wb_addr3;
    logic [L3*DW-1:0]    wb_data3;
    logic [NR*AW-1:0]    fwd_addr3 = '0;
    logic [NR-1:0]       fwd_hit3;
    logic [NR-1:0]       fwd_pending3;
    logic [NR*DW-1:0]    fwd_data3;

    spu_result_pipe u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_entry(in_entry),
        .tap(tap), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_pending(fwd_pending), .fwd_data(fwd_data)
    );

    spu_result_pipe #(.LANES(L3), .DEPTH(D3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid3), .in_entry(in_entry3),
        .tap(tap3), .wb_en(wb_en3), .wb_addr(wb_addr3), .wb_data(wb_data3),
        .fwd_addr(fwd_addr3), .fwd_hit(fwd_hit3), .fwd_pending(fwd_pending3), .fwd_data(fwd_data3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [L-1:0]  en;
        logic [L*AW-1:0] addr;
        logic [L*DW-1:0] data;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    bit      sb_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] mk(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                         input logic w, input logic [LW-1:0] lt);
        spu_entry_t e;
        e.data    = d;
        e.reg_dst = a;
        e.reg_wr  = w;
        e.latency = lt;
        e.unit_id = 3'd5;
        return pack_entry(e);
    endfunction

    function automatic logic [PW-1:0] rnd_entry();
        logic [DW-1:0] d;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        return mk(d, AW'($urandom_range(0, 3)), 1'($urandom()), LW'($urandom()));
    endfunction

    function automatic logic [PW-1:0] tap_of(input int l, input int k);
        return tap[((l*int'(D)) + (k-1))*int'(PW) +: PW];
    endfunction

    // Drive one issue cycle and queue the writeback expected DEPTH cycles later
    task automatic cycle_drive(input logic [L-1:0] v, input logic [PW-1:0] e0,
                               input logic [PW-1:0] e1, input logic fl);
        wb_exp_t x;
        logic [PW-1:0] ent [L];
        @(posedge clk);
        #1;
        in_valid = v;
        in_entry = {e1, e0};
        flush    = fl;
        ent[0] = (v[0] && !fl) ? e0 : '0;
        ent[1] = (v[1] && !fl) ? e1 : '0;
        x.due  = cyc + int'(D);
        x.en   = '0;
        x.addr = '0;
        x.data = '0;
        for (int l = 0; l < int'(L); l++) begin
            x.en[l]              = ent[l][UW+LW];
            x.addr[l*AW +: AW]   = ent[l][UW+LW+1 +: AW];
            x.data[l*DW +: DW]   = ent[l][UW+LW+1+AW +: DW];
        end
        if (x.en[0] && x.en[1] && (x.addr[0 +: AW] == x.addr[AW +: AW])) begin
            x.en[0]        = 1'b0;
            x.addr[0 +: AW] = '0;
            x.data[0 +: DW] = '0;
        end
        if (sb_en) sb_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_drive('0, '0, '0, 1'b0);
    endtask

    // Scoreboard: compare writeback every cycle against the queued expectation
    always @(negedge clk) begin
        if (sb_en && rst) begin
            checks++;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                wb_exp_t x;
                x = sb_q.pop_front();
                if (wb_en !== x.en || wb_addr !== x.addr || wb_data !== x.data) begin
                    errors++;
                    $display("FAIL wb_sb cyc=%0d en=%b exp=%b addr=%h exp=%h data=%h exp=%h",
                             cyc, wb_en, x.en, wb_addr, x.addr, wb_data, x.data);
                end
            end else if (wb_en !== '0) begin
                errors++;
                $display("FAIL wb_idle cyc=%0d en=%b exp=00", cyc, wb_en);
            end
        end
    end

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            in_valid = L'($urandom());
            flush    = 1'($urandom());
            for (int i = 0; i < int'(L*PW); i++) in_entry[i] = 1'($urandom());
            for (int i = 0; i < int'(NR*AW); i++) fwd_addr[i] = 1'($urandom());
            #1;
            checks++;
            if (tap !== '0 || wb_en !== '0 || wb_addr !== '0 || wb_data !== '0 ||
                fwd_hit !== '0 || fwd_pending !== '0 || fwd_data !== '0) begin
                errors++;
                $display("FAIL reset_hold: wb_en=%b hit=%b pend=%b tap_nz=%b exp all zero",
                         wb_en, fwd_hit, fwd_pending, |tap);
            end
        end
        @(posedge clk);
        #1;
        in_valid = '0;
        in_entry = '0;
        flush    = 1'b0;
        fwd_addr = '0;
        rst      = 1'b1;
        sb_en    = 1'b1;
        idle(1);
        checks++;
        if (tap !== '0 || wb_en !== '0 || tap3 !== '0) begin
            errors++;
            $display("FAIL reset_release: wb_en=%b tap_nz=%b exp zero", wb_en, |tap);
        end
        cycle_drive(2'b01, mk(128'h1234, 7'd1, 1'b1, 4'd3), '0, 1'b0);
        idle(7);
        checks++;
        if (wb_en !== 2'b01 || wb_addr[0 +: AW] !== 7'd1) begin
            errors++;
            $display("FAIL first_wb: wb_en=%b addr=%0d exp 01/1", wb_en, wb_addr[0 +: AW]);
        end
    endtask

    task automatic test_latency();
        logic [PW-1:0] e;
        logic [DW-1:0] aa;
        aa = {16{8'hAA}};
        e  = mk(aa, 7'd5, 1'b1, 4'd2);
        idle(int'(D));
        fwd_addr = '0;
        fwd_addr[0 +: AW] = 7'd5;
        cycle_drive(2'b01, e, '0, 1'b0);
        idle(1);
        checks++;
        if (fwd_pending[0] !== FWD || fwd_hit[0] !== 1'b0 || tap_of(0, 1) !== e) begin
            errors++;
            $display("FAIL lat_t1: pend=%b hit=%b exp %b/0 tap_ok=%b", fwd_pending[0], fwd_hit[0],
                     FWD, tap_of(0, 1) === e);
        end
        idle(1);
        checks++;
        if (fwd_hit[0] !== FWD || fwd_pending[0] !== 1'b0 ||
            fwd_data[0 +: DW] !== (FWD ? aa : '0)) begin
            errors++;
            $display("FAIL lat_t2: hit=%b pend=%b data=%h exp hit=%b", fwd_hit[0], fwd_pending[0],
                     fwd_data[0 +: DW], FWD);
        end
        idle(5);
        checks++;
        if (wb_en[0] !== 1'b1 || wb_addr[0 +: AW] !== 7'd5 || wb_data[0 +: DW] !== aa) begin
            errors++;
            $display("FAIL lat_wb: en=%b addr=%0d exp 1/5", wb_en[0], wb_addr[0 +: AW]);
        end
    endtask

    task automatic test_waw();
        logic [DW-1:0] d0, d1;
        logic          exp_hit, exp_pend;
        logic [DW-1:0] exp_data;
        d0 = {32{4'h1}};
        d1 = {32{4'h2}};
        idle(int'(D));
        fwd_addr = '0;
        fwd_addr[AW +: AW] = 7'd9;
        cycle_drive(2'b01, mk(d0, 7'd9, 1'b1, 4'd1), '0, 1'b0);
        cycle_drive(2'b10, '0, mk(d1, 7'd9, 1'b1, 4'd6), 1'b0);
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) idle(1);
            exp_hit  = FWD && (k == 1 || k == 7);
            exp_pend = FWD && (k > 1 && k < 7);
            exp_data = !FWD ? '0 : (k == 1) ? d0 : (k == 7) ? d1 : '0;
            checks++;
            if (fwd_hit[1] !== exp_hit || fwd_pending[1] !== exp_pend || fwd_data[DW +: DW] !== exp_data) begin
                errors++;
                $display("FAIL waw_k%0d: hit=%b pend=%b data=%h exp %b/%b/%h", k, fwd_hit[1],
                         fwd_pending[1], fwd_data[DW +: DW], exp_hit, exp_pend, exp_data);
            end
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] dy;
        dy = {8{16'hBEEF}};
        idle(int'(D));
        cycle_drive(2'b11, mk({8{16'h1111}}, 7'd3, 1'b1, 4'd1), mk(dy, 7'd3, 1'b1, 4'd4), 1'b0);
        idle(7);
        checks++;
        if (wb_en !== 2'b10 || wb_addr[AW +: AW] !== 7'd3 || wb_addr[0 +: AW] !== '0 ||
            wb_data[DW +: DW] !== dy || wb_data[0 +: DW] !== '0) begin
            errors++;
            $display("FAIL collision: en=%b addr=%h exp 10 addr1=3 lane0 zero", wb_en, wb_addr);
        end
    endtask

    task automatic test_flush();
        logic [PW-1:0] a0, a1;
        a0 = mk(128'hA0, 7'd10, 1'b1, 4'd2);
        a1 = mk(128'hA1, 7'd11, 1'b1, 4'd2);
        idle(int'(D));
        cycle_drive(2'b11, a0, a1, 1'b0);
        cycle_drive(2'b11, mk(128'hB0, 7'd12, 1'b1, 4'd1), mk(128'hB1, 7'd13, 1'b1, 4'd1), 1'b1);
        idle(1);
        checks++;
        if (tap_of(0, 1) !== '0 || tap_of(1, 1) !== '0 || tap_of(0, 2) !== a0 || tap_of(1, 2) !== a1) begin
            errors++;
            $display("FAIL flush_tap: s1_nz=%b s2_ok=%b exp s1 zero, s2 prior entries",
                     |{tap_of(0, 1), tap_of(1, 1)}, (tap_of(0, 2) === a0) && (tap_of(1, 2) === a1));
        end
        idle(5);
        checks++;
        if (wb_en !== 2'b11 || wb_addr !== {7'd11, 7'd10}) begin
            errors++;
            $display("FAIL flush_prior_wb: en=%b addr=%h exp 11", wb_en, wb_addr);
        end
        idle(1);
        checks++;
        if (wb_en !== 2'b00) begin
            errors++;
            $display("FAIL flush_killed_wb: en=%b exp 00", wb_en);
        end
    endtask

    task automatic test_mid_reset();
        logic [PW-1:0] e;
        e = mk(128'h77, 7'd20, 1'b1, 4'd3);
        idle(int'(D));
        cycle_drive(2'b01, e, '0, 1'b0);
        idle(1);
        checks++;
        if (tap_of(0, 1) !== e) begin
            errors++;
            $display("FAIL mid_reset_pre: stage1 lane0 not the issued entry");
        end
        #2;
        sb_en = 1'b0;
        rst   = 1'b0;
        sb_q.delete();
        #1;
        checks++;
        if (tap !== '0 || wb_en !== '0) begin
            errors++;
            $display("FAIL mid_reset_async: tap_nz=%b wb_en=%b exp zero", |tap, wb_en);
        end
        #3;
        rst   = 1'b1;
        sb_en = 1'b1;
        idle(int'(D) + 1);
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 40; c++) begin
            cycle_drive(L'($urandom()), rnd_entry(), rnd_entry(), 1'($urandom_range(0, 7) == 0));
        end
        idle(int'(D) + 1);
    endtask

    task automatic test_three_lane();
        logic [PW-1:0] e [L3];
        logic exp_hit, exp_pend;
        for (int l = 0; l < int'(L3); l++) e[l] = mk(DW'(32'hC0 + l), AW'(20 + l), 1'b1, 4'd9);
        fwd_addr3 = '0;
        fwd_addr3[0 +: AW] = 7'd21;
        idle(1);
        in_valid3 = 3'b111;
        in_entry3 = {e[2], e[1], e[0]};
        for (int k = 1; k <= int'(D3); k++) begin
            idle(1);
            in_valid3 = '0;
            in_entry3 = '0;
            exp_hit  = FWD && (k == int'(D3));
            exp_pend = FWD && (k < int'(D3));
            checks++;
            if (fwd_hit3[0] !== exp_hit || fwd_pending3[0] !== exp_pend ||
                fwd_data3[0 +: DW] !== (exp_hit ? DW'(32'hC1) : '0)) begin
                errors++;
                $display("FAIL lane3_fwd_k%0d: hit=%b pend=%b exp %b/%b", k, fwd_hit3[0],
                         fwd_pending3[0], exp_hit, exp_pend);
            end
            checks++;
            if (wb_en3 !== ((k == int'(D3)) ? 3'b111 : 3'b000) ||
                (k == int'(D3) && wb_addr3 !== {7'd22, 7'd21, 7'd20})) begin
                errors++;
                $display("FAIL lane3_wb_k%0d: en=%b addr=%h", k, wb_en3, wb_addr3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_waw();
        test_collision();
        test_flush();
        test_mid_reset();
        test_back_to_back();
        test_three_lane();
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
